// File: rtl/mem_wb_stage.sv
// MEM/WB stage: fixed-latency word-addressed data memory plus
// the writeback register that drives the register-file write port.
module mem_wb_stage #(
  parameter int MEM_WORDS   = 64,
  parameter int ADDR_BITS   = 6,
  parameter int MEM_LATENCY = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] st_value,
  input  logic [4:0]  dest,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        writeback_en,
  output logic        freeze,
  output logic        write_enable,
  output logic [4:0]  dest_wb,
  output logic [31:0] result_wb
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam int CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [31:0]          st_q, st_d;
  logic [4:0]           dst_q, dst_d;
  logic                 wr_q, wr_d;
  logic                 wb_q, wb_d;
  logic                 we_q, we_d;
  logic [4:0]           dwb_q, dwb_d;
  logic [31:0]          res_q, res_d;

  logic [31:0]          mem_q [MEM_WORDS];
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_idx;
  logic [31:0]          mem_wdata;

  logic                 fin;
  logic [ADDR_BITS-1:0] c_idx;
  logic [31:0]          c_st;
  logic [4:0]           c_dst;
  logic                 c_wr;
  logic                 c_wb;

  assign freeze       = (state_q == BUSY);
  assign write_enable = we_q;
  assign dest_wb      = dwb_q;
  assign result_wb    = res_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    st_d      = st_q;
    dst_d     = dst_q;
    wr_d      = wr_q;
    wb_d      = wb_q;
    we_d      = 1'b0;
    dwb_d     = dwb_q;
    res_d     = res_q;
    mem_we    = 1'b0;
    mem_idx   = idx_q;
    mem_wdata = st_q;
    fin       = 1'b0;
    c_idx     = idx_q;
    c_st      = st_q;
    c_dst     = dst_q;
    c_wr      = wr_q;
    c_wb      = wb_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!(mem_read || mem_write)) begin
            we_d  = writeback_en && (dest != 5'd0);
            dwb_d = dest;
            res_d = alu_result;
          end else if (MEM_LATENCY == 1) begin
            fin   = 1'b1;
            c_idx = alu_result[ADDR_BITS+1:2];
            c_st  = st_value;
            c_dst = dest;
            c_wr  = mem_write;
            c_wb  = writeback_en;
          end else begin
            idx_d   = alu_result[ADDR_BITS+1:2];
            st_d    = st_value;
            dst_d   = dest;
            wr_d    = mem_write;
            wb_d    = writeback_en;
            cnt_d   = CW'(MEM_LATENCY - 2);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
    endcase

    // A load reads the array before any same-edge store lands.
    if (fin) begin
      if (c_wr) begin
        mem_we    = 1'b1;
        mem_idx   = c_idx;
        mem_wdata = c_st;
      end else begin
        we_d  = c_wb && (c_dst != 5'd0);
        dwb_d = c_dst;
        res_d = mem_q[c_idx];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      st_q    <= '0;
      dst_q   <= '0;
      wr_q    <= 1'b0;
      wb_q    <= 1'b0;
      we_q    <= 1'b0;
      dwb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
      dst_q   <= dst_d;
      wr_q    <= wr_d;
      wb_q    <= wb_d;
      we_q    <= we_d;
      dwb_q   <= dwb_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: one instance at latency 3,
// one at latency 1, selected by sel.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iv = 1'b0;
  logic [31:0] alu = '0;
  logic [31:0] stv = '0;
  logic [4:0]  dst = '0;
  logic        mrd = 1'b0;
  logic        mwr = 1'b0;
  logic        wbe = 1'b0;
  logic        sel = 1'b0;

  logic        fz3, we3, fz1, we1;
  logic [4:0]  dw3, dw1;
  logic [31:0] rw3, rw1;

  logic        fz, we;
  logic [4:0]  dw;
  logic [31:0] rw;

  assign fz = sel ? fz1 : fz3;
  assign we = sel ? we1 : we3;
  assign dw = sel ? dw1 : dw3;
  assign rw = sel ? rw1 : rw3;

  mem_wb_stage #(.MEM_WORDS(64), .ADDR_BITS(6), .MEM_LATENCY(3)) dut (
    .clock(clock), .reset(reset), .in_valid(iv && !sel),
    .alu_result(alu), .st_value(stv), .dest(dst),
    .mem_read(mrd), .mem_write(mwr), .writeback_en(wbe),
    .freeze(fz3), .write_enable(we3), .dest_wb(dw3), .result_wb(rw3)
  );

  mem_wb_stage #(.MEM_WORDS(64), .ADDR_BITS(6), .MEM_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(iv && sel),
    .alu_result(alu), .st_value(stv), .dest(dst),
    .mem_read(mrd), .mem_write(mwr), .writeback_en(wbe),
    .freeze(fz1), .write_enable(we1), .dest_wb(dw1), .result_wb(rw1)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  d;
    logic [31:0] r;
    int          c;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m3 [64];
  logic [31:0] m1 [64];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          run = 0;
  int          fz1_hits = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (fz1) fz1_hits++;
    if (reset) begin
      run = 0;
    end else begin
      if (fz) begin
        run++;
      end else if (run != 0) begin
        chk("freeze_len", run, sel ? 1 - 1 : 3 - 1);
        run = 0;
      end
      if (we) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected", {27'd0, dw}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_dest", {27'd0, dw}, {27'd0, e.d});
          chk("wb_data", rw, e.r);
          chk("wb_cycle", cyc, e.c);
        end
      end
    end
  end

  task automatic clear_models();
    for (int i = 0; i < 64; i++) begin
      m3[i] = '0;
      m1[i] = '0;
    end
    sb.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] s,
                       input logic [4:0] d, input logic rd,
                       input logic wr, input logic wb);
    int   n;
    int   lat;
    exp_t e;
    n = 0;
    lat = sel ? 1 : 3;
    @(negedge clock);
    alu = a; stv = s; dst = d;
    mrd = rd; mwr = wr; wbe = wb; iv = 1'b1;
    while (fz && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("accept_timeout", n, 0);
    e.d = d;
    e.c = cyc + ((rd || wr) ? lat : 1);
    if (wr) begin
      if (sel) m1[a[7:2]] = s;
      else m3[a[7:2]] = s;
    end else begin
      e.r = rd ? (sel ? m1[a[7:2]] : m3[a[7:2]]) : a;
      if (wb && d != 5'd0) sb.push_back(e);
    end
    @(posedge clock);
    #1 iv = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_models();
    #1;
    chk("rst_freeze", {31'd0, fz3}, 0);
    chk("rst_we", {31'd0, we3}, 0);
    chk("rst_dest", {27'd0, dw3}, 0);
    chk("rst_res", rw3, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_models();
    @(negedge clock);
    do_reset();
    idle(2);

    issue(32'h0000_1234, 0, 5'd5, 0, 0, 1);
    idle(2);

    issue(32'h10, 32'hDEAD_BEEF, 5'd0, 0, 1, 0);
    issue(32'h10, 0, 5'd7, 1, 0, 1);
    idle(4);

    issue(32'h110, 0, 5'd9, 1, 0, 1);
    idle(4);

    issue(32'h10, 0, 5'd0, 1, 0, 1);
    issue(32'h55, 0, 5'd3, 0, 0, 0);
    issue(32'h14, 32'hA5A5_0F0F, 5'd4, 1, 1, 1);
    issue(32'h17, 0, 5'd6, 1, 0, 1);
    idle(4);

    issue(32'h20, 32'h55, 5'd0, 0, 1, 0);
    #2;
    chk("busy_freeze", {31'd0, fz3}, 1);
    reset = 1'b1;
    clear_models();
    #1;
    chk("rst_busy_freeze", {31'd0, fz3}, 0);
    @(negedge clock);
    reset = 1'b0;
    issue(32'h20, 0, 5'd8, 1, 0, 1);
    idle(4);

    issue(32'h0000_0AAA, 0, 5'd1, 0, 0, 1);
    issue(32'h10, 0, 5'd2, 1, 0, 1);
    issue(32'h0000_0BBB, 0, 5'd3, 0, 0, 1);
    issue(32'h24, 32'h1357_9BDF, 5'd0, 0, 1, 0);
    issue(32'h24, 0, 5'd10, 1, 0, 1);
    idle(4);

    sel = 1'b1;
    idle(1);
    issue(32'h30, 32'hCAFE_F00D, 5'd0, 0, 1, 0);
    issue(32'h0000_0111, 0, 5'd11, 0, 0, 1);
    issue(32'h130, 0, 5'd12, 1, 0, 1);
    issue(32'h0000_0222, 0, 5'd13, 0, 0, 1);
    issue(32'h30, 0, 5'd0, 1, 0, 1);
    idle(4);

    chk("lat1_no_freeze", fz1_hits, 0);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access plus MEM/WB pipeline stage.
- Accepts EXE results (ALU result, store data, destination, control bits), performs load/store on an internal word-addressed data memory with a configurable fixed latency, and registers the writeback triple.
- Drives write_enable / dest_wb / result_wb back into the decode stage's register file (the write end of the register-file write port).
- Asserts freeze upstream while a multi-cycle memory access is outstanding.

Parameters:
- MEM_WORDS, 64, data memory depth in 32-bit words (power of 2).
- ADDR_BITS, 6, log2(MEM_WORDS).
- MEM_LATENCY, 3, cycles per load/store access (min 1).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  EXE stage presents a valid instruction.
- alu_result  input  32  ALU output; byte address for load/store.
- st_value  input  32  store data (reg2 forwarded from decode).
- dest  input  5  destination register.
- mem_read  input  1  instruction is a load.
- mem_write  input  1  instruction is a store.
- writeback_en  input  1  instruction writes a register.
- freeze  output  1  upstream must hold its current instruction.
- write_enable  output  1  register-file write strobe.
- dest_wb  output  5  register-file write address.
- result_wb  output  32  register-file write data.

Behaviour:
- Reset (async, any time):
  - state=IDLE, counter=0, freeze=0.
  - write_enable=0, dest_wb=0, result_wb=0.
  - All memory words cleared to 0.
  - An in-flight access is aborted; a pending store is not performed.
- Word index = alu_result[ADDR_BITS+1:2]. Upper bits are ignored, so addresses wrap modulo MEM_WORDS*4. Low two bits are ignored (no alignment fault).
- Accept: an instruction is accepted on a rising edge when state==IDLE and in_valid==1. freeze is 0 in IDLE, so acceptance never stalls there.
- Non-memory instruction (mem_read=0, mem_write=0):
  - Latency 1.
  - At the accepting edge: write_enable<=writeback_en & (dest!=0), dest_wb<=dest, result_wb<=alu_result.
- Memory instruction with MEM_LATENCY==1: completes at the accepting edge, same as the completion rule below; no BUSY state.
- Memory instruction with MEM_LATENCY>1:
  - At the accepting edge: latch address, st_value, dest, control bits; state<=BUSY; counter<=MEM_LATENCY-2. The WB register loads a bubble.
- BUSY:
  - freeze=1 (combinational from state).
  - Inputs are ignored; upstream holds.
  - Each edge with counter!=0: counter decrements, WB register loads a bubble.
  - Edge with counter==0: completion, state<=IDLE.
- Completion:
  - Store: mem[idx]<=latched st_value; write_enable<=0.
  - Load: result_wb<=mem[idx] (value before any same-edge write); dest_wb<=latched dest; write_enable<=writeback_en & (dest!=0).
- Total latency: accept edge to writeback edge = MEM_LATENCY edges.
- Freeze: high for exactly MEM_LATENCY-1 cycles per memory instruction.
- Bubble: write_enable<=0. dest_wb and result_wb hold their prior values.
- Every edge not described above (IDLE with in_valid=0) loads a bubble. A given writeback is therefore visible for exactly one cycle.
- mem_read and mem_write both 1: treated as a store only; no writeback.
- dest==0: write_enable is always 0 (r0 is never written).
- Back-to-back: the instruction held during freeze is accepted on the edge after completion (the first IDLE cycle). There are no dead cycles beyond freeze.

Test Plan:
1. Reset, then ALU op (alu_result=0x0000_1234, dest=5, writeback_en=1, in_valid=1) -> next edge: write_enable=1, dest_wb=5, result_wb=0x1234; following idle edge: write_enable=0.
2. Store st_value=0xDEAD_BEEF to alu_result=0x10 (MEM_LATENCY=3), then load from 0x10 to dest=7:
   - freeze high for 2 cycles per access.
   - Store causes no write_enable.
   - Load yields write_enable=1, dest_wb=7, result_wb=0xDEADBEEF, exactly 3 edges after load acceptance.
3. Load from alu_result=0x110 after a store to 0x10 (wrap, 64 words) -> result_wb equals the stored value.
4. Load with dest=0 -> write_enable stays 0 throughout; ALU op with writeback_en=0 -> write_enable 0.
5. Assert reset during BUSY of a store (value 0x55 to 0x20), release, load 0x20 -> result_wb=0; freeze=0 immediately on reset.
6. Alternating ALU/load/ALU with in_valid held and freeze honored -> three writebacks in order, no duplicates, no lost instruction. Repeat with MEM_LATENCY=1: freeze never asserts.
